// File: rtl/iob_ibex_axi_bridge.sv
// Ibex req/gnt to single-beat AXI4 manager bridge; optional response watchdog via IOB_IBEX_AXI_TIMEOUT_EN.
// One transaction in flight, rvalid at least 3 cycles after grant; each AXI channel holds valid until ready.
module iob_ibex_axi_bridge #(
  parameter int                     AXI_ID_W   = 1,
  parameter int                     AXI_ADDR_W = 32,
  parameter int                     AXI_DATA_W = 32,
  parameter int                     AXI_LEN_W  = 8,
  parameter logic [AXI_ID_W-1:0]    ID_VAL     = '0,
  parameter int                     TIMEOUT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      arst_i,
  input  logic                      ibex_req_i,
  input  logic                      ibex_we_i,
  input  logic [3:0]                ibex_be_i,
  input  logic [31:0]               ibex_addr_i,
  input  logic [31:0]               ibex_wdata_i,
  output logic                      ibex_gnt_o,
  output logic                      ibex_rvalid_o,
  output logic [31:0]               ibex_rdata_o,
  output logic                      ibex_err_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [AXI_ADDR_W-1:0]     awaddr_o,
  output logic [AXI_ID_W-1:0]       awid_o,
  output logic [AXI_LEN_W-1:0]      awlen_o,
  output logic [2:0]                awsize_o,
  output logic [1:0]                awburst_o,
  output logic [2:0]                awprot_o,
  output logic                      awlock_o,
  output logic [3:0]                awcache_o,
  output logic [3:0]                awqos_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  output logic [AXI_DATA_W-1:0]     wdata_o,
  output logic [AXI_DATA_W/8-1:0]   wstrb_o,
  output logic                      wlast_o,
  input  logic                      bvalid_i,
  output logic                      bready_o,
  input  logic [1:0]                bresp_i,
  input  logic [AXI_ID_W-1:0]       bid_i,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [AXI_ADDR_W-1:0]     araddr_o,
  output logic [AXI_ID_W-1:0]       arid_o,
  output logic [AXI_LEN_W-1:0]      arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  output logic [2:0]                arprot_o,
  output logic                      arlock_o,
  output logic [3:0]                arcache_o,
  output logic [3:0]                arqos_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [AXI_DATA_W-1:0]     rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic [AXI_ID_W-1:0]       rid_i,
  input  logic                      rlast_i
);

  localparam int          NLANES    = AXI_DATA_W / 32;
  localparam int          STRB_W    = AXI_DATA_W / 8;
  localparam logic [31:0] LANE_MASK = 32'(NLANES - 1);

`ifdef IOB_IBEX_AXI_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP, S_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP
  } state_t;
  localparam int unused_timeout_w = TIMEOUT_W;
`endif

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
  logic [AXI_DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    to_q, to_d;
`endif

  logic [31:0]             lane_in, lane_cur;
  logic [AXI_DATA_W-1:0]   rd_lane;
  logic                    gnt;
  logic                    rvalid;
  logic                    unused_sig;

  // Lane index is the word offset within one AXI data beat.
  assign lane_in  = {2'b00, ibex_addr_i[31:2]} & LANE_MASK;
  assign lane_cur = {2'b00, addr_q[31:2]} & LANE_MASK;
  assign rd_lane  = rdata_i >> (lane_cur * 32);
  assign gnt      = (state_q == S_IDLE) && ibex_req_i && cke_i;

  assign unused_sig = ^{ibex_addr_i[1:0], bid_i, rid_i, rlast_i, rd_lane};

  assign ibex_gnt_o    = gnt;
  assign ibex_rvalid_o = rvalid && cke_i;
  assign ibex_rdata_o  = rdata_q;
  assign ibex_err_o    = err_q;

  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = 1'b1;
  assign awid_o    = ID_VAL;
  assign arid_o    = ID_VAL;
  assign awlen_o   = '0;
  assign arlen_o   = '0;
  assign awsize_o  = 3'b010;
  assign arsize_o  = 3'b010;
  assign awburst_o = 2'b01;
  assign arburst_o = 2'b01;
  assign awprot_o  = 3'b000;
  assign arprot_o  = 3'b000;
  assign awlock_o  = 1'b0;
  assign arlock_o  = 1'b0;
  assign awcache_o = 4'b0011;
  assign arcache_o = 4'b0011;
  assign awqos_o   = 4'b0000;
  assign arqos_o   = 4'b0000;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
    cnt_d     = cnt_q;
    we_d      = we_q;
    to_d      = to_q;
`endif
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    arvalid_o = 1'b0;
    bready_o  = 1'b0;
    rready_o  = 1'b0;
    rvalid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt) begin
          addr_d    = AXI_ADDR_W'({ibex_addr_i[31:2], 2'b00});
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
          we_d      = ibex_we_i;
`endif
          if (ibex_we_i) begin
            wdata_d = {NLANES{ibex_wdata_i}};
            wstrb_d = STRB_W'(ibex_be_i) << (lane_in * 4);
            state_d = S_WR;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end

      S_WR: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_done_d = aw_done_q || awready_i;
        w_done_d  = w_done_q || wready_i;
        if (aw_done_d && w_done_d) begin
          state_d = S_WR_RESP;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          err_d   = (bresp_i != 2'b00);
          state_d = S_RESP;
        end
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
        else if (&cnt_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
`endif
      end

      S_RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = S_RD_DATA;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          rdata_d = rd_lane[31:0];
          err_d   = (rresp_i != 2'b00);
          state_d = S_RESP;
        end
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
        else if (&cnt_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
`endif
      end

      S_RESP: begin
        rvalid  = 1'b1;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
        state_d = to_q ? S_DRAIN : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end

`ifdef IOB_IBEX_AXI_TIMEOUT_EN
      // The late response still has to be consumed so the interconnect stays in sync.
      S_DRAIN: begin
        bready_o = we_q;
        rready_o = !we_q;
        if (we_q ? bvalid_i : rvalid_i) begin
          to_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
      cnt_q     <= '0;
      we_q      <= 1'b0;
      to_q      <= 1'b0;
`endif
    end else if (cke_i) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
`ifdef IOB_IBEX_AXI_TIMEOUT_EN
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      to_q      <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_ibex_axi_bridge.sv
// Scoreboard bench for iob_ibex_axi_bridge with a 64-bit AXI data bus.
// Driver pushes expected AXI payloads and Ibex responses; a negedge monitor pops and compares them.
module tb_iob_ibex_axi_bridge;

  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic            clk_i = 1'b0;
  logic            cke_i;
  logic            arst_i;
  logic            ibex_req_i, ibex_we_i;
  logic [3:0]      ibex_be_i;
  logic [31:0]     ibex_addr_i, ibex_wdata_i;
  logic            ibex_gnt_o, ibex_rvalid_o, ibex_err_o;
  logic [31:0]     ibex_rdata_o;
  logic            awvalid_o, awready_i, awlock_o, wvalid_o, wready_i, wlast_o;
  logic [31:0]     awaddr_o, araddr_o;
  logic [0:0]      awid_o, arid_o, bid_i, rid_i;
  logic [7:0]      awlen_o, arlen_o;
  logic [2:0]      awsize_o, arsize_o, awprot_o, arprot_o;
  logic [1:0]      awburst_o, arburst_o, bresp_i, rresp_i;
  logic [3:0]      awcache_o, awqos_o, arcache_o, arqos_o;
  logic [DW-1:0]   wdata_o, rdata_i;
  logic [SW-1:0]   wstrb_o;
  logic            bvalid_i, bready_o, arvalid_o, arready_i, arlock_o;
  logic            rvalid_i, rready_o, rlast_i;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_resp[$];
  logic [63:0] exp_aw[$];
  logic [63:0] exp_ar[$];
  logic [63:0] exp_wd[$];
  logic [63:0] exp_ws[$];

  iob_ibex_axi_bridge #(
    .AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(DW), .AXI_LEN_W(8),
    .ID_VAL(1'b0), .TIMEOUT_W(4)
  ) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .ibex_req_i(ibex_req_i), .ibex_we_i(ibex_we_i), .ibex_be_i(ibex_be_i),
    .ibex_addr_i(ibex_addr_i), .ibex_wdata_i(ibex_wdata_i),
    .ibex_gnt_o(ibex_gnt_o), .ibex_rvalid_o(ibex_rvalid_o),
    .ibex_rdata_o(ibex_rdata_o), .ibex_err_o(ibex_err_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awid_o(awid_o),
    .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o), .awprot_o(awprot_o),
    .awlock_o(awlock_o), .awcache_o(awcache_o), .awqos_o(awqos_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wlast_o(wlast_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i), .bid_i(bid_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arid_o(arid_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arprot_o(arprot_o),
    .arlock_o(arlock_o), .arcache_o(arcache_o), .arqos_o(arqos_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rid_i(rid_i), .rlast_i(rlast_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {56'd0, ibex_gnt_o, ibex_rvalid_o, ibex_err_o, awvalid_o,
                        wvalid_o, arvalid_o, bready_o, rready_o}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, ibex_rdata_o}, 64'd0);
    chk({tag, "_addr"}, {awaddr_o, araddr_o}, 64'd0);
    chk({tag, "_wdata"}, wdata_o, 64'd0);
    chk({tag, "_wstrb"}, {56'd0, wstrb_o}, 64'd0);
  endtask

  // Directed transaction: d1 = AW/AR ready delay, d2 = W/R valid-or-ready delay, d3 = B delay.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int d1, input int d2, input int d3,
                        input logic [1:0] resp, input logic [63:0] rdat, input bit keep_req,
                        input logic [31:0] e_addr, input logic [63:0] e_wdata,
                        input logic [7:0] e_wstrb, input logic [31:0] e_rdata, input bit e_err);
    int  n;
    bit  awd, wdn;
    if (we) begin
      exp_aw.push_back({32'd0, e_addr});
      exp_wd.push_back(e_wdata);
      exp_ws.push_back({56'd0, e_wstrb});
    end else begin
      exp_ar.push_back({32'd0, e_addr});
    end
    exp_resp.push_back({31'd0, e_err, e_rdata});

    ibex_req_i = 1'b1; ibex_we_i = we; ibex_be_i = be;
    ibex_addr_i = addr; ibex_wdata_i = wd;
    #1;
    n = 0;
    while (!ibex_gnt_o && n < 50) begin
      @(posedge clk_i); #2; n++;
    end
    if (n == 50) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      ibex_req_i = 1'b0;
      return;
    end
    step();
    if (!keep_req) ibex_req_i = 1'b0;

    if (we) begin
      chk("wr_valids_after_gnt", {62'd0, awvalid_o, wvalid_o}, 64'd3);
      awd = 1'b0; wdn = 1'b0; n = 0;
      while (!(awd && wdn) && n < 100) begin
        awready_i = !awd && (n >= d1);
        wready_i  = !wdn && (n >= d2);
        #1;
        if (awvalid_o && awready_i) awd = 1'b1;
        if (wvalid_o && wready_i) wdn = 1'b1;
        step(); n++;
      end
      awready_i = 1'b0; wready_i = 1'b0;
      if (n == 100) chk("aw_w_timeout", 64'd0, 64'd1);
      n = 0;
      bresp_i = resp;
      while (n < 100) begin
        bvalid_i = (n >= d3);
        #1;
        if (bvalid_i && bready_o) begin
          step();
          break;
        end
        step(); n++;
      end
      bvalid_i = 1'b0;
      if (n == 100) chk("b_timeout", 64'd0, 64'd1);
    end else begin
      chk("rd_valid_after_gnt", {63'd0, arvalid_o}, 64'd1);
      n = 0;
      while (n < 100) begin
        arready_i = (n >= d1);
        #1;
        if (arvalid_o && arready_i) begin
          step();
          break;
        end
        step(); n++;
      end
      arready_i = 1'b0;
      if (n == 100) chk("ar_timeout", 64'd0, 64'd1);
      n = 0;
      rdata_i = rdat; rresp_i = resp;
      while (n < 100) begin
        rvalid_i = (n >= d2);
        #1;
        if (rvalid_i && rready_o) begin
          step();
          break;
        end
        step(); n++;
      end
      rvalid_i = 1'b0;
      if (n == 100) chk("r_timeout", 64'd0, 64'd1);
    end

    n = 0;
    while (!ibex_rvalid_o && n < 20) begin
      step(); n++;
    end
    if (n == 20) chk("rvalid_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: scoreboard pops, grant exclusivity, rvalid pulse width, payload stability.
  bit            busy, prev_rv, aw_pend, w_pend, ar_pend;
  logic [31:0]   aw_prev, ar_prev;
  logic [63:0]   wd_prev;
  logic [7:0]    ws_prev;
  logic [63:0]   got;

  always @(negedge clk_i) begin
    if (arst_i) begin
      busy = 1'b0; prev_rv = 1'b0;
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    end else begin
      if (ibex_gnt_o) begin
        chk("gnt_exclusive", {61'd0, busy, ibex_rvalid_o,
            awvalid_o | wvalid_o | arvalid_o | bready_o | rready_o}, 64'd0);
        busy = 1'b1;
      end
      if (ibex_rvalid_o) begin
        chk("rvalid_pulse", {63'd0, prev_rv}, 64'd0);
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          got = exp_resp.pop_front();
          chk("resp_err_rdata", {31'd0, ibex_err_o, ibex_rdata_o}, got);
        end
        busy = 1'b0;
      end
      prev_rv = ibex_rvalid_o;

      if (aw_pend) chk("aw_stable", {31'd0, awvalid_o, awaddr_o}, {31'd0, 1'b1, aw_prev});
      if (w_pend) begin
        chk("w_stable_data", wvalid_o ? wdata_o : ~wd_prev, wd_prev);
        chk("w_stable_strb", {56'd0, wstrb_o}, {56'd0, ws_prev});
      end
      if (ar_pend) chk("ar_stable", {31'd0, arvalid_o, araddr_o}, {31'd0, 1'b1, ar_prev});

      if (awvalid_o && awready_i) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else chk("awaddr", {32'd0, awaddr_o}, exp_aw.pop_front());
      end
      if (wvalid_o && wready_i) begin
        if (exp_wd.size() == 0) begin
          chk("w_unexpected", 64'd1, 64'd0);
        end else begin
          chk("wdata", wdata_o, exp_wd.pop_front());
          chk("wstrb", {56'd0, wstrb_o}, exp_ws.pop_front());
        end
      end
      if (arvalid_o && arready_i) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
        else chk("araddr", {32'd0, araddr_o}, exp_ar.pop_front());
      end

      aw_pend = awvalid_o && !awready_i; aw_prev = awaddr_o;
      w_pend  = wvalid_o && !wready_i;   wd_prev = wdata_o; ws_prev = wstrb_o;
      ar_pend = arvalid_o && !arready_i; ar_prev = araddr_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    cke_i = 1'b1; arst_i = 1'b1;
    ibex_req_i = 1'b0; ibex_we_i = 1'b0; ibex_be_i = 4'h0;
    ibex_addr_i = 32'h0; ibex_wdata_i = 32'h0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00; bid_i = 1'b0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rid_i = 1'b0;
    rlast_i = 1'b1;
    step(); step();
    chk_reset_outputs("reset");
    chk("const_aw", {36'd0, awlen_o, awsize_o, awburst_o, awprot_o, awlock_o, awcache_o,
                     awqos_o, wlast_o, awid_o}, {36'd0, 8'd0, 3'b010, 2'b01, 3'd0, 1'b0,
                     4'b0011, 4'd0, 1'b1, 1'b0});
    chk("const_ar", {37'd0, arlen_o, arsize_o, arburst_o, arprot_o, arlock_o, arcache_o,
                     arqos_o, arid_o}, {37'd0, 8'd0, 3'b010, 2'b01, 3'd0, 1'b0, 4'b0011,
                     4'd0, 1'b0});
    arst_i = 1'b0;
    step();

    // we addr be wdata d1 d2 d3 resp rdata keep | exp addr, wdata, wstrb, rdata, err
    do_txn(0, 32'h100, 4'hF, 32'h0, 2, 1, 0, 2'b00, 64'h11111111_DEADBEEF, 0,
           32'h100, 64'h0, 8'h00, 32'hDEADBEEF, 0);
    do_txn(1, 32'h00C, 4'b0011, 32'h1234, 0, 0, 2, 2'b00, 64'h0, 0,
           32'h00C, 64'h00001234_00001234, 8'h30, 32'hDEADBEEF, 0);
    do_txn(1, 32'h020, 4'hF, 32'hCAFEF00D, 3, 0, 1, 2'b10, 64'h0, 0,
           32'h020, 64'hCAFEF00D_CAFEF00D, 8'h0F, 32'hDEADBEEF, 1);
    do_txn(0, 32'h10E, 4'hF, 32'h0, 0, 3, 0, 2'b00, 64'hA5A5A5A5_5A5A5A5A, 1,
           32'h10C, 64'h0, 8'h00, 32'hA5A5A5A5, 0);
    do_txn(1, 32'h207, 4'b1000, 32'h89ABCDEF, 2, 2, 0, 2'b00, 64'h0, 1,
           32'h204, 64'h89ABCDEF_89ABCDEF, 8'h80, 32'hA5A5A5A5, 0);
    do_txn(0, 32'h008, 4'hF, 32'h0, 1, 0, 0, 2'b11, 64'h0BADF00D_12345678, 0,
           32'h008, 64'h0, 8'h00, 32'h12345678, 1);
    do_txn(1, 32'h018, 4'b0101, 32'h00FF00FF, 0, 4, 1, 2'b00, 64'h0, 0,
           32'h018, 64'h00FF00FF_00FF00FF, 8'h05, 32'h12345678, 0);
    ibex_req_i = 1'b0;
    step();

    // Asynchronous reset while waiting for read data.
    exp_ar.push_back(64'h200);
    ibex_req_i = 1'b1; ibex_we_i = 1'b0; ibex_addr_i = 32'h200;
    #1;
    n = 0;
    while (!ibex_gnt_o && n < 20) begin
      @(posedge clk_i); #2; n++;
    end
    chk("rst_seq_gnt", {63'd0, ibex_gnt_o}, 64'd1);
    step();
    ibex_req_i = 1'b0;
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    chk("rst_seq_rready", {63'd0, rready_o}, 64'd1);
    #2 arst_i = 1'b1;
    #1 chk_reset_outputs("async_reset");
    #4 arst_i = 1'b0;
    step();
    do_txn(0, 32'h044, 4'hF, 32'h0, 1, 1, 0, 2'b00, 64'h76543210_00000000, 0,
           32'h044, 64'h0, 8'h00, 32'h76543210, 0);
    ibex_req_i = 1'b0;
    step();

`ifdef IOB_IBEX_AXI_TIMEOUT_EN
    exp_ar.push_back(64'h300);
    exp_resp.push_back({31'd0, 1'b1, 32'h0});
    ibex_req_i = 1'b1; ibex_we_i = 1'b0; ibex_addr_i = 32'h300;
    #1;
    n = 0;
    while (!ibex_gnt_o && n < 20) begin
      @(posedge clk_i); #2; n++;
    end
    step();
    ibex_req_i = 1'b0;
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ibex_rvalid_o) break;
      if (rready_o) n++;
      step();
    end
    chk("timeout_wait_cycles", n, 64'd16);
    ibex_req_i = 1'b1; ibex_addr_i = 32'h304;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drain_no_gnt", {62'd0, ibex_gnt_o, rready_o}, 64'd1);
    end
    rvalid_i = 1'b1; rdata_i = 64'hFFFFFFFF_FFFFFFFF; rresp_i = 2'b00;
    ibex_req_i = 1'b0;
    step();
    rvalid_i = 1'b0;
    do_txn(0, 32'h304, 4'hF, 32'h0, 0, 1, 0, 2'b00, 64'hC0FFEE00_00000000, 0,
           32'h304, 64'h0, 8'h00, 32'hC0FFEE00, 0);
    ibex_req_i = 1'b0;
    step();
`endif

    step(); step();
    chk("queues_empty", 64'(exp_resp.size() + exp_aw.size() + exp_ar.size() + exp_wd.size()),
        64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_ibex_axi_bridge.md
Name: iob_ibex_axi_bridge

Overview:
Parametrised bridge from the Ibex LSU/instruction request-grant interface to a single AXI4 manager port. A state machine handshakes each AXI channel independently and tracks one transaction at a time. It supports AXI data buses wider than 32 bits through lane steering. AXI errors are returned on the Ibex rvalid/err pair. It sits between an Ibex core port and the system AXI interconnect.

Parameters:
AXI_ID_W, 1, AXI ID width; the ID is a constant ID_VAL on both AR and AW.
AXI_ADDR_W, 32, AXI byte-address width; must be >= 32.
AXI_DATA_W, 32, AXI data width; must be 32, 64 or 128.
AXI_LEN_W, 8, AXI burst-length field width.
ID_VAL, 0, constant value driven on awid_o and arid_o.
TIMEOUT_W, 16, width of the response watchdog counter; used only with the optional feature.

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; when 0, all state is frozen
arst_i  in  1  asynchronous active-high reset
ibex_req_i  in  1  request
ibex_we_i  in  1  1 = write
ibex_be_i  in  4  byte enables
ibex_addr_i  in  32  byte address; bits [1:0] are ignored
ibex_wdata_i  in  32  write data
ibex_gnt_o  out  1  request accepted
ibex_rvalid_o  out  1  response valid, one-cycle pulse
ibex_rdata_o  out  32  read data
ibex_err_o  out  1  error, qualified by ibex_rvalid_o
awvalid_o/awready_i/awaddr_o[AXI_ADDR_W]/awid_o/awlen_o/awsize_o[3]/awburst_o[2]/awprot_o[3]/awlock_o/awcache_o[4]/awqos_o[4]  AXI4 AW channel
wvalid_o/wready_i/wdata_o[AXI_DATA_W]/wstrb_o[AXI_DATA_W/8]/wlast_o  AXI4 W channel
bvalid_i/bready_o/bresp_i[2]/bid_i  AXI4 B channel
arvalid_o/arready_i/araddr_o/arid_o/arlen_o/arsize_o/arburst_o/arprot_o/arlock_o/arcache_o/arqos_o  AXI4 AR channel
rvalid_i/rready_o/rdata_i[AXI_DATA_W]/rresp_i[2]/rid_i/rlast_i  AXI4 R channel

Behaviour:
- Reset values:
  - Every valid and ready output is 0.
  - ibex_gnt_o, ibex_rvalid_o and ibex_err_o are 0.
  - ibex_rdata_o, awaddr_o, araddr_o, wdata_o and wstrb_o are 0.
  - The state machine is in IDLE.
- Constant outputs:
  - len = 0, size = 3'b010, burst = 2'b01 (INCR), wlast_o = 1.
  - prot = 0, lock = 0, cache = 4'b0011, qos = 0.
- States: IDLE, WR (AW/W pending), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - ibex_gnt_o = ibex_req_i, combinationally. It is asserted only in IDLE.
  - On req & gnt, the bridge registers the aligned address {addr[31:2], 2'b00}, zero-extended to AXI_ADDR_W, together with be, wdata and we.
  - Next state is WR when we = 1, otherwise RD_ADDR.
  - awvalid_o/wvalid_o (write) or arvalid_o (read) rise in the cycle after grant.
- WR:
  - awvalid_o and wvalid_o are independent.
  - Each valid drops after its own handshake; either order and a simultaneous handshake are all legal.
  - The bridge moves to WR_RESP when both handshakes are done.
  - Valids never drop before ready.
  - Address and data stay stable while valid is high.
- WR_RESP: bready_o = 1. On bvalid_i the bridge captures err = (bresp_i != 2'b00) and moves to RESP.
- RD_ADDR: arvalid_o is held until arready_i, then the bridge moves to RD_DATA.
- RD_DATA:
  - rready_o = 1.
  - On rvalid_i the bridge captures the 32-bit lane of rdata_i selected by addr[log2(AXI_DATA_W/8)-1:2], and err = (rresp_i != 0).
  - It then moves to RESP.
- RESP:
  - ibex_rvalid_o = 1 for exactly one cycle, with ibex_err_o and ibex_rdata_o.
  - ibex_rdata_o holds its last value afterwards.
  - Next state is IDLE.
  - A new request is granted no earlier than the cycle after the rvalid pulse.
- Write lane steering:
  - wdata_o replicates ibex_wdata_i across all 32-bit lanes.
  - wstrb_o = be << (4 * lane), with all other strobe bits 0.
  - For AXI_DATA_W = 32 the lane is always 0.
- Channel ready outputs:
  - bready_o is asserted only in WR_RESP; rready_o only in RD_DATA.
  - A bvalid_i or rvalid_i in any other state is ignored.
- A deasserted ibex_req_i after grant has no effect: the transaction always completes.
- Asynchronous reset mid-transaction returns the bridge to IDLE immediately and drops all valids. The interconnect must be reset together with the bridge.
- cke_i = 0 freezes state and registers, and gates gnt.

Optional Feature:
Macro: IOB_IBEX_AXI_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entry to WR_RESP/RD_DATA and increments each cycle in those states.
  - On reaching all-ones, the bridge enters RESP with err = 1 and rdata = 0.
  - It then enters DRAIN instead of IDLE.
  - DRAIN keeps the waiting ready (bready_o or rready_o) at 1 and gnt at 0 until the late response handshakes, which is then discarded. The bridge then returns to IDLE.
- When undefined: no counter and no DRAIN state; the bridge waits indefinitely.

Test Plan:
- Read, AXI_DATA_W = 32: addr 0x100, arready after 2 cycles, rdata 0xDEADBEEF, rresp OKAY -> araddr 0x100, exactly one rvalid pulse with rdata 0xDEADBEEF and err = 0.
- Write, AXI_DATA_W = 64: addr 0x0C, be 4'b0011, wdata 0x1234 -> wstrb 8'h30, wdata 64'h0000123400001234, awaddr 0x0C, one rvalid pulse after bvalid.
- W handshake 3 cycles before AW, then AW, then B with SLVERR -> no extra W beat, awvalid held until awready, rvalid with err = 1.
- Back-to-back requests held high -> second gnt no earlier than the cycle after the first rvalid; stable AXI payloads verified under random ready stalls.
- arst_i pulsed while in RD_DATA -> all outputs return to reset values asynchronously; a following read completes normally.
- IOB_IBEX_AXI_TIMEOUT_EN, TIMEOUT_W = 4, no rvalid for 20 cycles -> rvalid with err = 1 at count 15, no gnt until the late rvalid is drained.
